// File: rtl/rsm_controller.sv
// rtl/rsm_controller.sv - instruction latch, decoder and control FSM for the Simple RISC Machine datapath
module rsm_controller (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        s,
    input  logic [15:0] in,
    output logic        w,
    output logic        illegal,
    output logic [15:0] sximm8,
    output logic [15:0] sximm5,
    output logic [2:0]  readnum,
    output logic [2:0]  writenum,
    output logic        write,
    output logic [1:0]  vsel,
    output logic        loada,
    output logic        loadb,
    output logic        asel,
    output logic        bsel,
    output logic        loadc,
    output logic        loads,
    output logic [1:0]  shift,
    output logic [1:0]  ALUop
);

    localparam logic [2:0] S_WAIT      = 3'd0;
    localparam logic [2:0] S_DECODE    = 3'd1;
    localparam logic [2:0] S_WRITE_IMM = 3'd2;
    localparam logic [2:0] S_GET_A     = 3'd3;
    localparam logic [2:0] S_GET_B     = 3'd4;
    localparam logic [2:0] S_ALU       = 3'd5;
    localparam logic [2:0] S_WRITE_REG = 3'd6;

    logic [2:0]  r_state;
    logic [15:0] r_ir;

    logic [2:0] w_opcode;
    logic [1:0] w_op;
    logic [2:0] w_rn;
    logic [2:0] w_rd;
    logic [1:0] w_sh;
    logic [2:0] w_rm;
    logic       w_mov_imm;
    logic       w_mov_reg;
    logic       w_alu_op;
    logic       w_mvn;
    logic       w_cmp;

    assign w_opcode  = r_ir[15:13];
    assign w_op      = r_ir[12:11];
    assign w_rn      = r_ir[10:8];
    assign w_rd      = r_ir[7:5];
    assign w_sh      = r_ir[4:3];
    assign w_rm      = r_ir[2:0];

    assign w_mov_imm = (w_opcode == 3'b110) && (w_op == 2'b10);
    assign w_mov_reg = (w_opcode == 3'b110) && (w_op == 2'b00);
    assign w_alu_op  = (w_opcode == 3'b101);
    assign w_mvn     = w_alu_op && (w_op == 2'b11);
    assign w_cmp     = w_alu_op && (w_op == 2'b01);

    assign sximm8 = {{8{r_ir[7]}}, r_ir[7:0]};
    assign sximm5 = {{11{r_ir[4]}}, r_ir[4:0]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_WAIT;
            r_ir    <= 16'd0;
        end else begin
            case (r_state)
                S_WAIT: begin
                    if (s) begin
                        r_ir    <= in;
                        r_state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (w_mov_imm)
                        r_state <= S_WRITE_IMM;
                    else if (w_mov_reg || w_mvn)
                        r_state <= S_GET_B;
                    else if (w_alu_op)
                        r_state <= S_GET_A;
                    else
                        r_state <= S_WAIT;
                end
                S_WRITE_IMM: r_state <= S_WAIT;
                S_GET_A:     r_state <= S_GET_B;
                S_GET_B:     r_state <= S_ALU;
                S_ALU:       r_state <= w_cmp ? S_WAIT : S_WRITE_REG;
                S_WRITE_REG: r_state <= S_WAIT;
                default:     r_state <= S_WAIT;
            endcase
        end
    end

    always_comb begin
        w        = 1'b0;
        illegal  = 1'b0;
        readnum  = 3'd0;
        writenum = 3'd0;
        write    = 1'b0;
        vsel     = 2'b00;
        loada    = 1'b0;
        loadb    = 1'b0;
        asel     = 1'b0;
        bsel     = 1'b0;
        loadc    = 1'b0;
        loads    = 1'b0;
        shift    = 2'b00;
        ALUop    = 2'b00;
        case (r_state)
            S_WAIT:   w = 1'b1;
            S_DECODE: illegal = !(w_mov_imm || w_mov_reg || w_alu_op);
            S_WRITE_IMM: begin
                write    = 1'b1;
                writenum = w_rn;
                vsel     = 2'b01;
            end
            S_GET_A: begin
                readnum = w_rn;
                loada   = 1'b1;
            end
            S_GET_B: begin
                readnum = w_rm;
                loadb   = 1'b1;
                shift   = w_sh;
            end
            S_ALU: begin
                // MOV reg and MVN pass B through with A forced to zero
                shift = w_sh;
                if (w_mov_reg) begin
                    asel  = 1'b1;
                    ALUop = 2'b00;
                end else if (w_mvn) begin
                    asel  = 1'b1;
                    ALUop = 2'b11;
                end else begin
                    ALUop = w_op;
                end
                loads = w_cmp;
                loadc = !w_cmp;
            end
            S_WRITE_REG: begin
                write    = 1'b1;
                writenum = w_rd;
                vsel     = 2'b11;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_rsm_controller.sv
// tb/tb_rsm_controller.sv - directed self-checking bench for rsm_controller
module tb_rsm_controller;

    logic        clk;
    logic        rst_n;
    logic        s;
    logic [15:0] in;
    logic        w;
    logic        illegal;
    logic [15:0] sximm8;
    logic [15:0] sximm5;
    logic [2:0]  readnum;
    logic [2:0]  writenum;
    logic        write;
    logic [1:0]  vsel;
    logic        loada;
    logic        loadb;
    logic        asel;
    logic        bsel;
    logic        loadc;
    logic        loads;
    logic [1:0]  shift;
    logic [1:0]  ALUop;

    int total = 0;
    int bad   = 0;

    rsm_controller dut (
        .clk(clk), .rst_n(rst_n), .s(s), .in(in), .w(w), .illegal(illegal),
        .sximm8(sximm8), .sximm5(sximm5), .readnum(readnum), .writenum(writenum),
        .write(write), .vsel(vsel), .loada(loada), .loadb(loadb), .asel(asel),
        .bsel(bsel), .loadc(loadc), .loads(loads), .shift(shift), .ALUop(ALUop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // packed view: w ill write wn rn vsel la lb as bs lc ls shift aluop
    function automatic logic [20:0] mk(input logic ww, input logic ill, input logic wr,
                                       input logic [2:0] wn, input logic [2:0] rn,
                                       input logic [1:0] vs, input logic la, input logic lb,
                                       input logic as_, input logic bs, input logic lc,
                                       input logic ls, input logic [1:0] sh, input logic [1:0] op);
        return {ww, ill, wr, wn, rn, vs, la, lb, as_, bs, lc, ls, sh, op};
    endfunction

    function automatic logic [20:0] ctl();
        return {w, illegal, write, writenum, readnum, vsel, loada, loadb, asel, bsel,
                loadc, loads, shift, ALUop};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic start(input logic [15:0] instr);
        in = instr;
        s  = 1'b1;
        @(negedge clk);
        s  = 1'b0;
        in = 16'hFFFF;
    endtask

    localparam logic [20:0] IDLE = 21'h100000;
    localparam logic [20:0] BUSY = 21'h000000;

    initial begin
        rst_n = 1'b0;
        s     = 1'b1;
        in    = 16'hD007;
        @(negedge clk);
        @(negedge clk);
        chk("reset_ctl", 32'(ctl()), 32'(IDLE));
        chk("reset_ir", 32'(sximm8), 32'h0);
        s     = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_hold", 32'(ctl()), 32'(IDLE));

        // MOV R0,#7
        start(16'hD007);
        chk("movi0_dec", 32'(ctl()), 32'(BUSY));
        @(negedge clk);
        chk("movi0_wr", 32'(ctl()), 32'(mk(0,0,1,3'd0,3'd0,2'b01,0,0,0,0,0,0,2'b00,2'b00)));
        chk("movi0_imm", 32'(sximm8), 32'h0007);
        @(negedge clk);
        chk("movi0_done", 32'(ctl()), 32'(IDLE));

        // MOV R4,#-16
        start(16'hD4F0);
        chk("movi4_dec", 32'(ctl()), 32'(BUSY));
        @(negedge clk);
        chk("movi4_wr", 32'(ctl()), 32'(mk(0,0,1,3'd4,3'd0,2'b01,0,0,0,0,0,0,2'b00,2'b00)));
        chk("movi4_imm8", 32'(sximm8), 32'h0000FFF0);
        chk("movi4_imm5", 32'(sximm5), 32'h0000FFF0);
        @(negedge clk);
        chk("movi4_done", 32'(ctl()), 32'(IDLE));

        // ADD R2,R1,R0,LSL#1
        start(16'hA148);
        chk("add_dec", 32'(ctl()), 32'(BUSY));
        @(negedge clk);
        chk("add_geta", 32'(ctl()), 32'(mk(0,0,0,3'd0,3'd1,2'b00,1,0,0,0,0,0,2'b00,2'b00)));
        @(negedge clk);
        chk("add_getb", 32'(ctl()), 32'(mk(0,0,0,3'd0,3'd0,2'b00,0,1,0,0,0,0,2'b01,2'b00)));
        @(negedge clk);
        chk("add_alu", 32'(ctl()), 32'(mk(0,0,0,3'd0,3'd0,2'b00,0,0,0,0,1,0,2'b01,2'b00)));
        @(negedge clk);
        chk("add_wr", 32'(ctl()), 32'(mk(0,0,1,3'd2,3'd0,2'b11,0,0,0,0,0,0,2'b00,2'b00)));
        @(negedge clk);
        chk("add_done", 32'(ctl()), 32'(IDLE));

        // CMP R5,R6,LSR#1
        start(16'hAD16);
        chk("cmp_dec", 32'(ctl()), 32'(BUSY));
        @(negedge clk);
        chk("cmp_geta", 32'(ctl()), 32'(mk(0,0,0,3'd0,3'd5,2'b00,1,0,0,0,0,0,2'b00,2'b00)));
        @(negedge clk);
        chk("cmp_getb", 32'(ctl()), 32'(mk(0,0,0,3'd0,3'd6,2'b00,0,1,0,0,0,0,2'b10,2'b00)));
        @(negedge clk);
        chk("cmp_alu", 32'(ctl()), 32'(mk(0,0,0,3'd0,3'd0,2'b00,0,0,0,0,0,1,2'b10,2'b01)));
        @(negedge clk);
        chk("cmp_done", 32'(ctl()), 32'(IDLE));

        // MVN R3,R7
        start(16'hB867);
        chk("mvn_dec", 32'(ctl()), 32'(BUSY));
        @(negedge clk);
        chk("mvn_getb", 32'(ctl()), 32'(mk(0,0,0,3'd0,3'd7,2'b00,0,1,0,0,0,0,2'b00,2'b00)));
        @(negedge clk);
        chk("mvn_alu", 32'(ctl()), 32'(mk(0,0,0,3'd0,3'd0,2'b00,0,0,1,0,1,0,2'b00,2'b11)));
        @(negedge clk);
        chk("mvn_wr", 32'(ctl()), 32'(mk(0,0,1,3'd3,3'd0,2'b11,0,0,0,0,0,0,2'b00,2'b00)));
        @(negedge clk);
        chk("mvn_done", 32'(ctl()), 32'(IDLE));

        // MOV R1,R2,ASR#1
        start(16'hC03A);
        @(negedge clk);
        chk("movr_getb", 32'(ctl()), 32'(mk(0,0,0,3'd0,3'd2,2'b00,0,1,0,0,0,0,2'b11,2'b00)));
        @(negedge clk);
        chk("movr_alu", 32'(ctl()), 32'(mk(0,0,0,3'd0,3'd0,2'b00,0,0,1,0,1,0,2'b11,2'b00)));
        @(negedge clk);
        chk("movr_wr", 32'(ctl()), 32'(mk(0,0,1,3'd1,3'd0,2'b11,0,0,0,0,0,0,2'b00,2'b00)));
        @(negedge clk);
        chk("movr_done", 32'(ctl()), 32'(IDLE));

        // unsupported encoding
        start(16'h0000);
        chk("ill_dec", 32'(ctl()), 32'(mk(0,1,0,3'd0,3'd0,2'b00,0,0,0,0,0,0,2'b00,2'b00)));
        @(negedge clk);
        chk("ill_done", 32'(ctl()), 32'(IDLE));

        // reset during GET_B of ADD aborts before WRITE_REG
        start(16'hA148);
        @(negedge clk);
        @(negedge clk);
        chk("abort_getb", 32'(ctl()), 32'(mk(0,0,0,3'd0,3'd0,2'b00,0,1,0,0,0,0,2'b01,2'b00)));
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort_wait", 32'(ctl()), 32'(IDLE));
        chk("abort_ir", 32'(sximm8), 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort_nowr", 32'(ctl()), 32'(IDLE));
        end

        // s held high: next instruction latched on the single WAIT edge
        in = 16'hD007;
        s  = 1'b1;
        @(negedge clk);
        in = 16'hD4F0;
        chk("b2b_dec1", 32'(ctl()), 32'(BUSY));
        @(negedge clk);
        chk("b2b_wr1", 32'(ctl()), 32'(mk(0,0,1,3'd0,3'd0,2'b01,0,0,0,0,0,0,2'b00,2'b00)));
        @(negedge clk);
        chk("b2b_wait", 32'(ctl()), 32'(IDLE));
        @(negedge clk);
        s  = 1'b0;
        in = 16'h0000;
        chk("b2b_dec2", 32'(ctl()), 32'(BUSY));
        chk("b2b_imm2", 32'(sximm8), 32'h0000FFF0);
        @(negedge clk);
        chk("b2b_wr2", 32'(ctl()), 32'(mk(0,0,1,3'd4,3'd0,2'b01,0,0,0,0,0,0,2'b00,2'b00)));
        @(negedge clk);
        chk("b2b_done", 32'(ctl()), 32'(IDLE));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rsm_controller.md
Name: rsm_controller

Overview:
- Instruction decoder and control FSM for the Simple RISC Machine datapath.
- Latches a 16-bit instruction on a start strobe, then sequences every datapath control input over multiple cycles: register-file read/write, A/B/C/status loads, mux selects, shift and ALU op.
- Drives `datapath` from the other side of its control interface.
- Raises `w` when idle and ready for the next instruction.

Parameters:
- None.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk
- s  input  1  start strobe; sampled only in WAIT
- in  input  16  instruction word; latched when s=1 in WAIT
- w  output  1  1 = idle (WAIT state), ready to accept s
- illegal  output  1  one-cycle pulse: latched instruction is not a supported encoding
- sximm8  output  16  sign-extended ir[7:0]
- sximm5  output  16  sign-extended ir[4:0]
- readnum  output  3  register file read index
- writenum  output  3  register file write index
- write  output  1  register file write enable
- vsel  output  2  writeback select: 00 mdata, 01 sximm8, 10 PC, 11 datapath_out (C)
- loada  output  1  load A register
- loadb  output  1  load B register
- asel  output  1  1 = ALU A input forced to 0
- bsel  output  1  1 = ALU B input from sximm5
- loadc  output  1  load C register
- loads  output  1  load status (Z/N/V) register
- shift  output  2  shifter op: 00 none, 01 LSL1, 10 LSR1, 11 ASR1
- ALUop  output  2  00 add, 01 sub, 10 and, 11 not-B

Behaviour:
- Reset: rst_n is synchronous and active-low. rst_n=0 at a rising edge gives the following on the next cycle:
  - state=WAIT, ir=0, w=1, illegal=0.
  - All enables/selects = 0.
  - Reset mid-instruction aborts it; no further write/load is issued.
- Instruction fields: opcode=ir[15:13], op=ir[12:11], Rn=ir[10:8], Rd=ir[7:5], sh=ir[4:3], Rm=ir[2:0].
- Supported encodings:
  - 110/10: MOV Rn,#imm8
  - 110/00: MOV Rd,Rm{,sh}
  - 101/00: ADD Rd,Rn,Rm{,sh}
  - 101/01: CMP Rn,Rm{,sh}
  - 101/10: AND Rd,Rn,Rm{,sh}
  - 101/11: MVN Rd,Rm{,sh}
- States: WAIT, DECODE, WRITE_IMM, GET_A, GET_B, ALU, WRITE_REG. State is registered; all outputs are Moore, decoded from state and ir.
- WAIT:
  - w=1.
  - s=1 at an edge: ir<=in, go to DECODE.
  - s=0: stay.
- s is ignored in all other states. `in` is not sampled outside WAIT.
- DECODE: no enables asserted. Next state:
  - MOV imm -> WRITE_IMM
  - MOV reg, MVN -> GET_B
  - ADD, CMP, AND -> GET_A
  - unsupported -> WAIT, with illegal=1 during DECODE
- WRITE_IMM: write=1, writenum=Rn, vsel=01 -> WAIT.
- GET_A: readnum=Rn, loada=1 -> GET_B.
- GET_B: readnum=Rm, loadb=1, shift=sh -> ALU.
- ALU: shift=sh, bsel=0.
  - MOV reg: asel=1, ALUop=00.
  - MVN: asel=1, ALUop=11.
  - ADD/CMP/AND: asel=0, ALUop=op.
  - CMP: loads=1, loadc=0 -> WAIT.
  - All others: loadc=1, loads=0 -> WRITE_REG.
- WRITE_REG: write=1, writenum=Rd, vsel=11 -> WAIT.
- Defaults in every state unless stated above:
  - readnum=0, writenum=0, write=0, loada/loadb/loadc/loads=0.
  - vsel=00, asel=0, bsel=0, shift=00, ALUop=00.
- sximm8 and sximm5 derive from ir continuously, in every state.
- Non-WAIT cycles per instruction: MOV imm 2, MOV reg 4, MVN 4, CMP 4, ADD/AND 5. w returns to 1 the cycle after the final state.
- s=1 held continuously: the next instruction is latched on the first WAIT edge. There is no gap cycle beyond the single WAIT cycle.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles with s=1 -> w=1, all enables 0, ir not latched.
- MOV R0,#7 (in=16'hD007): DECODE, then WRITE_IMM with write=1, writenum=0, vsel=01, sximm8=16'd7; w=1 exactly 2 cycles after start. Repeat with MOV R4,#-16 (16'hD4F0) -> sximm8=16'hFFF0, writenum=4.
- ADD R2,R1,R0,LSL#1 (16'hA148): GET_A readnum=1/loada=1; GET_B readnum=0/loadb=1/shift=01; ALU loadc=1/ALUop=00/asel=0; WRITE_REG writenum=2/vsel=11/write=1. Total 5 busy cycles. With the datapath connected and R0=7, R1=2, R2 must read 16.
- CMP R5,R6,LSR#1 (16'hAD16): ALU state loads=1, loadc=0, ALUop=01, shift=10; no write in any cycle; back in WAIT after 4 cycles.
- MVN R3,R7 (16'hB867): GET_B readnum=7 -> ALU asel=1, ALUop=11 -> WRITE_REG writenum=3.
- Illegal/abort: in=16'h0000 -> illegal pulse 1 cycle in DECODE, no write/load, w=1 next cycle. Separately, rst_n=0 during GET_B of an ADD -> WAIT next cycle, no WRITE_REG ever issued.
